diffeq_out_buffer: RTL and testbench
====================================

Name: diffeq_out_buffer

Overview:
- Output buffer stage directly downstream of the difference-equation filter.
- Captures one signed N-bit filter sample per clock when i_valid is high and holds it in a DEPTH-entry first-word-fall-through FIFO.
- Presents samples to a slower consumer through a valid/ready handshake.
- Reports fill level, an almost-full watermark and a sticky overflow flag, because the filter produces a sample every cycle and cannot be stalled.

Parameters:
- N, 16, sample word length in bits; must match the filter word length.
- DEPTH, 8, number of FIFO entries; power of two, at least 2.
- AF_LEVEL, 6, fill count at or above which o_almost_full asserts; 1 <= AF_LEVEL <= DEPTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous reset, active high.
- i_x  input  N  signed sample from the filter output o_y.
- i_valid  input  1  i_x holds a sample to capture this cycle.
- i_ready  input  1  consumer accepts o_data this cycle.
- i_clr_ovf  input  1  clears the sticky overflow flag.
- o_data  output  N  signed head-of-FIFO sample.
- o_valid  output  1  FIFO not empty; o_data is meaningful.
- o_count  output  $clog2(DEPTH)+1  current fill level, 0..DEPTH.
- o_full  output  1  o_count == DEPTH.
- o_almost_full  output  1  o_count >= AF_LEVEL.
- o_ovf  output  1  sticky flag: at least one sample was dropped.

Behaviour:
- Reset (asynchronous, while i_rst is high):
  - write pointer, read pointer and count = 0; all storage entries = 0.
  - o_ovf = 0, o_valid = 0, o_data = 0, o_full = 0, o_almost_full = 0.
- Write: occurs when i_valid && (!o_full || rd). i_x is stored at the write pointer, which then increments modulo DEPTH and wraps from DEPTH-1 to 0.
- Read: rd = o_valid && i_ready. The read pointer increments modulo DEPTH. i_ready while empty has no effect.
- First-word fall-through:
  - o_data = storage[read pointer], driven from registered storage with no extra register stage.
  - A sample written at edge k appears on o_data with o_valid = 1 after edge k (write-to-output latency 1 cycle).
- Count: +1 on write only, -1 on read only, unchanged on both or neither. o_full and o_almost_full are decoded from count.
- Simultaneous write and read:
  - When full, both proceed: the count stays at DEPTH and no sample is dropped.
  - When empty, read is not possible (o_valid = 0), so only the write occurs.
- Overflow: i_valid && o_full && !rd drops i_x; storage and pointers are unchanged and o_ovf is set at the next edge.
- o_ovf clear:
  - i_clr_ovf clears o_ovf at the next edge.
  - Set takes priority when a drop and i_clr_ovf occur in the same cycle.
  - o_ovf holds until cleared or reset.
- Data is passed bit-exact; no saturation or rescaling in this block.
- Reset asserted mid-operation empties the FIFO immediately. Contents are lost and the consumer must treat o_valid falling as a flush.
- No X propagation: storage is reset, so o_data is defined even when o_valid = 0.

Decomposition:
- Shared package diffeq_pkg:
  - constant DIFFEQ_N = 16, shared by the filter and this buffer.
  - constant DIFFEQ_BUF_DEPTH = 8.
  - localparam helper for pointer width, $clog2(DEPTH).
- One sub-module: wrap_ptr, a modulo-DEPTH pointer with increment enable and asynchronous active-high reset. It is instantiated twice, for the read and write pointers.

Test Plan:
- Reset then idle: i_rst pulse, no i_valid for 5 cycles -> o_valid = 0, o_count = 0, o_data = 0, o_ovf = 0 throughout.
- Single pass-through: write i_x = -3 for one cycle with i_ready = 1 -> next cycle o_valid = 1, o_data = -3 (0xFFFD); following cycle o_valid = 0, o_count = 0.
- Fill and watermark: write 1..8 on consecutive cycles with i_ready = 0 -> o_almost_full rises after the 6th write, o_full after the 8th, o_count = 8, o_ovf = 0; then drain with i_ready = 1 -> o_data sequence 1..8 in order.
- Overflow and clear: with the FIFO full of 1..8, write 9 with i_ready = 0 -> o_ovf = 1, contents unchanged (drain gives 1..8); pulse i_clr_ovf -> o_ovf = 0.
- Full with simultaneous read/write: with the FIFO full of 1..8, drive i_valid = 1 and i_ready = 1 for 8 cycles with i_x = 100..107 -> o_count stays 8, o_ovf = 0, o_data shows 1..8, then 100..107 on drain.
- Wrap-around and mid-operation reset: 20 writes, interleaved so the count stays at or below 4, check in-order data across pointer wrap; then assert i_rst with count = 3 -> o_valid = 0 and o_count = 0 immediately, before any clock edge.

Source files
------------

// File: rtl/diffeq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : diffeq_pkg
// Description : Constants and helpers shared by the difference-equation
//               filter and its output buffer.
//               - DIFFEQ_N           : sample word length
//               - DIFFEQ_BUF_DEPTH   : output buffer depth
//               - buf_ptr_width()    : pointer width for a given depth
// Revision    : 1.0 - initial release
// ============================================================================
package diffeq_pkg;

    localparam int DIFFEQ_N         = 16;
    localparam int DIFFEQ_BUF_DEPTH = 8;

    // A depth of 1 would give a zero-width pointer; clamp to one bit.
    function automatic int buf_ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int DIFFEQ_BUF_PTR_W = buf_ptr_width(DIFFEQ_BUF_DEPTH);

endpackage : diffeq_pkg
`default_nettype wire

// File: rtl/diffeq_out_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : diffeq_out_buffer_if
// Description : Sample/handshake bundle between the filter, the output
//               buffer and the downstream consumer.
//               slave  : buffer side (captures i_x, presents o_data + status)
//               master : filter/consumer side
//               Ports  : i_x, i_valid, i_ready, i_clr_ovf,
//                        o_data, o_valid, o_count, o_full, o_almost_full, o_ovf
// Revision    : 1.0 - initial release
// ============================================================================
interface diffeq_out_buffer_if
    import diffeq_pkg::*;
#(
    parameter int N     = DIFFEQ_N,
    parameter int DEPTH = DIFFEQ_BUF_DEPTH
);
    localparam int CNT_W = buf_ptr_width(DEPTH) + 1;

    logic signed [N-1:0]     i_x;
    logic                    i_valid;
    logic                    i_ready;
    logic                    i_clr_ovf;
    logic signed [N-1:0]     o_data;
    logic                    o_valid;
    logic        [CNT_W-1:0] o_count;
    logic                    o_full;
    logic                    o_almost_full;
    logic                    o_ovf;

    modport slave (
        input  i_x, i_valid, i_ready, i_clr_ovf,
        output o_data, o_valid, o_count, o_full, o_almost_full, o_ovf
    );

    modport master (
        output i_x, i_valid, i_ready, i_clr_ovf,
        input  o_data, o_valid, o_count, o_full, o_almost_full, o_ovf
    );

endinterface : diffeq_out_buffer_if
`default_nettype wire

// File: rtl/wrap_ptr.sv
`default_nettype none
// ============================================================================
// Module      : wrap_ptr
// Description : Modulo-DEPTH pointer with increment enable.
//               clk    : clock
//               i_rst  : asynchronous reset, active high (pointer -> 0)
//               i_inc  : advance pointer this cycle
//               o_ptr  : current pointer value, 0..DEPTH-1
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_ptr
    import diffeq_pkg::*;
#(
    parameter int DEPTH = DIFFEQ_BUF_DEPTH
)(
    input  wire logic                            clk,
    input  wire logic                            i_rst,
    input  wire logic                            i_inc,
    output logic [buf_ptr_width(DEPTH)-1:0]      o_ptr
);
    localparam int                PTR_W  = buf_ptr_width(DEPTH);
    localparam logic [PTR_W-1:0]  C_LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Explicit wrap keeps the pointer correct even if DEPTH were not a
    // power of two.
    always_comb begin
        ptr_d = ptr_q;
        if (i_inc) begin
            ptr_d = (ptr_q == C_LAST) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_ptr = ptr_q;

endmodule : wrap_ptr
`default_nettype wire

// File: rtl/diffeq_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : diffeq_out_buffer
// Description : First-word-fall-through FIFO between the difference-equation
//               filter (which cannot be stalled) and a slower consumer.
//               clk    : clock
//               i_rst  : asynchronous reset, active high; flushes the FIFO
//               bus    : slave modport of diffeq_out_buffer_if
//                        in : i_x, i_valid, i_ready, i_clr_ovf
//                        out: o_data, o_valid, o_count, o_full,
//                             o_almost_full, o_ovf (sticky drop flag)
//               N and DEPTH must match the parameters of the connected bus.
// Revision    : 1.0 - initial release
// ============================================================================
module diffeq_out_buffer
    import diffeq_pkg::*;
#(
    parameter int N        = DIFFEQ_N,
    parameter int DEPTH    = DIFFEQ_BUF_DEPTH,
    parameter int AF_LEVEL = 6
)(
    input  wire logic          clk,
    input  wire logic          i_rst,
    diffeq_out_buffer_if.slave bus
);
    localparam int                PTR_W   = buf_ptr_width(DEPTH);
    localparam int                CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]  C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  C_AF    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0]  C_ONE   = CNT_W'(1);

    logic signed [N-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    w_wr_ptr;
    logic [PTR_W-1:0]    w_rd_ptr;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;
    logic                ovf_q;
    logic                ovf_d;

    logic                w_valid;
    logic                w_full;
    logic                w_rd;
    logic                w_wr;
    logic                w_drop;

    // ------------------------------------------------------------------
    // Handshake decode. When full, a concurrent read frees the slot the
    // incoming sample needs, so the write still goes ahead.
    // ------------------------------------------------------------------
    always_comb begin
        w_valid = (count_q != '0);
        w_full  = (count_q == C_DEPTH);
        w_rd    = w_valid && bus.i_ready;
        w_wr    = bus.i_valid && (!w_full || w_rd);
        w_drop  = bus.i_valid && w_full && !w_rd;
    end

    wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .i_rst (i_rst),
        .i_inc (w_wr),
        .o_ptr (w_wr_ptr)
    );

    wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .i_rst (i_rst),
        .i_inc (w_rd),
        .o_ptr (w_rd_ptr)
    );

    // ------------------------------------------------------------------
    // Storage is reset so o_data is never X, even while empty.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_wr) begin
            mem_q[w_wr_ptr] <= bus.i_x;
        end
    end

    // ------------------------------------------------------------------
    // Fill level and sticky overflow.
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        unique case ({w_wr, w_rd})
            2'b10:   count_d = count_q + C_ONE;
            2'b01:   count_d = count_q - C_ONE;
            default: count_d = count_q;
        endcase
    end

    // A drop in the same cycle as a clear wins, so no loss goes unreported.
    always_comb begin
        ovf_d = ovf_q;
        if (w_drop) begin
            ovf_d = 1'b1;
        end else if (bus.i_clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head of FIFO straight from storage (fall-through).
    // ------------------------------------------------------------------
    assign bus.o_data        = mem_q[w_rd_ptr];
    assign bus.o_valid       = w_valid;
    assign bus.o_count       = count_q;
    assign bus.o_full        = w_full;
    assign bus.o_almost_full = (count_q >= C_AF);
    assign bus.o_ovf         = ovf_q;

endmodule : diffeq_out_buffer
`default_nettype wire

// File: tb/tb_diffeq_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_diffeq_out_buffer
// Description : Scoreboard bench for diffeq_out_buffer. The stimulus process
//               pushes each sample expected to be accepted; a monitor pops
//               and compares on every handshake. Status outputs are checked
//               against hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_diffeq_out_buffer;

    localparam int N     = 16;
    localparam int DEPTH = 8;

    logic clk;
    logic i_rst;

    diffeq_out_buffer_if #(.N(N), .DEPTH(DEPTH)) bus ();

    diffeq_out_buffer #(.N(N), .DEPTH(DEPTH), .AF_LEVEL(6)) dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;
    logic signed [N-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs; push the sample if it is expected to be kept.
    task automatic drv(input logic v, input logic signed [N-1:0] x,
                       input logic r, input logic c, input logic push);
        bus.i_valid   = v;
        bus.i_x       = x;
        bus.i_ready   = r;
        bus.i_clr_ovf = c;
        if (push) exp_q.push_back(x);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: inputs change just after the rising edge, so at the falling
    // edge they show what the next rising edge will act on.
    always @(negedge clk) begin
        if (bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got 0x%04h expected no output at %0t",
                         bus.o_data, $time);
            end else begin
                logic signed [N-1:0] e;
                e = exp_q.pop_front();
                chk("pop_data", 32'(bus.o_data), 32'(e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.o_valid), 32'd0);
        chk("rst_count", 32'(bus.o_count), 32'd0);
        chk("rst_data",  32'(bus.o_data),  32'd0);
        chk("rst_ovf",   32'(bus.o_ovf),   32'd0);
        chk("rst_af",    32'(bus.o_almost_full), 32'd0);
        #2 i_rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_valid", 32'(bus.o_valid), 32'd0);
            chk("idle_count", 32'(bus.o_count), 32'd0);
            chk("idle_data",  32'(bus.o_data),  32'd0);
            chk("idle_ovf",   32'(bus.o_ovf),   32'd0);
        end

        // Single pass-through of -3.
        drv(1'b1, -16'sd3, 1'b1, 1'b0, 1'b1);
        tick();
        chk("pass_valid", 32'(bus.o_valid), 32'd1);
        chk("pass_data",  32'(bus.o_data),  32'(-16'sd3));
        chk("pass_count", 32'(bus.o_count), 32'd1);
        drv(1'b0, '0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("pass_empty_valid", 32'(bus.o_valid), 32'd0);
        chk("pass_empty_count", 32'(bus.o_count), 32'd0);

        // Fill 1..8 with the consumer stalled.
        for (int i = 1; i <= 8; i++) begin
            drv(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
            tick();
            chk("fill_count", 32'(bus.o_count), 32'(i));
            chk("fill_af",    32'(bus.o_almost_full), (i >= 6) ? 32'd1 : 32'd0);
            chk("fill_full",  32'(bus.o_full), (i == 8) ? 32'd1 : 32'd0);
        end
        chk("fill_ovf", 32'(bus.o_ovf), 32'd0);

        // Overflow: 9 is dropped, head stays 1.
        drv(1'b1, 16'sd9, 1'b0, 1'b0, 1'b0);
        tick();
        chk("ovf_set",   32'(bus.o_ovf),   32'd1);
        chk("ovf_count", 32'(bus.o_count), 32'd8);
        chk("ovf_head",  32'(bus.o_data),  32'd1);
        // Drop and clear together: set wins.
        drv(1'b1, 16'sd10, 1'b0, 1'b1, 1'b0);
        tick();
        chk("ovf_prio", 32'(bus.o_ovf), 32'd1);
        drv(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("ovf_clr", 32'(bus.o_ovf), 32'd0);

        // Drain: monitor sees 1..8.
        drv(1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (8) tick();
        chk("drain1_valid", 32'(bus.o_valid), 32'd0);
        chk("drain1_count", 32'(bus.o_count), 32'd0);

        // Refill, then read and write together while full.
        for (int i = 1; i <= 8; i++) begin
            drv(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
            tick();
        end
        chk("refill_full", 32'(bus.o_full), 32'd1);
        for (int k = 0; k < 8; k++) begin
            drv(1'b1, 16'(100 + k), 1'b1, 1'b0, 1'b1);
            tick();
            chk("rw_count", 32'(bus.o_count), 32'd8);
            chk("rw_ovf",   32'(bus.o_ovf),   32'd0);
        end
        drv(1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (8) tick();
        chk("drain2_valid", 32'(bus.o_valid), 32'd0);
        chk("drain2_count", 32'(bus.o_count), 32'd0);

        // Wrap-around: consumer skips one cycle in eight, count grows by one
        // every eight writes: 1, 2, 3.
        for (int i = 0; i < 20; i++) begin
            drv(1'b1, 16'(200 + i), ((i % 8) != 0), 1'b0, 1'b1);
            tick();
            chk("wrap_count", 32'(bus.o_count), 32'(1 + i / 8));
        end

        // Asynchronous reset with three samples held.
        drv(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #2 i_rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.o_valid), 32'd0);
        chk("arst_count", 32'(bus.o_count), 32'd0);
        chk("arst_data",  32'(bus.o_data),  32'd0);
        exp_q.delete();
        @(posedge clk);
        #3 i_rst = 1'b0;
        chk("arst_ovf", 32'(bus.o_ovf), 32'd0);

        // Buffer still works after the flush.
        drv(1'b1, 16'sh0055, 1'b1, 1'b0, 1'b1);
        tick();
        chk("post_rst_data", 32'(bus.o_data), 32'h0055);
        drv(1'b0, '0, 1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        chk("post_rst_empty", 32'(bus.o_valid), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_diffeq_out_buffer
`default_nettype wire
